bullet_pattern_gen: RTL and testbench

//  Parametrised N-bullet sprite engine for the battle box. Each bullet is a filled disc that

---
 rtl/bullet_pkg.sv | 26 ++
 rtl/bullet_disc.sv | 33 +++
 rtl/bullet_pattern_gen.sv | 165 ++++++++++++++++
 tb/tb_bullet_pattern_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and constants for the battle-box bullet sprite engine.
package bullet_pkg;

  localparam int unsigned COORD_W = 10;

  localparam logic [COORD_W-1:0] H_LAST = 10'd639;
  localparam logic [COORD_W-1:0] V_LAST = 10'd479;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // Start centre Y of bullet idx; bullets are staggered by phase inside the bounce range.
  function automatic logic [COORD_W-1:0] start_y(int unsigned idx, int unsigned phase,
                                                 int unsigned y_min, int unsigned y_max);
    return COORD_W'(y_min + ((idx * phase) % (y_max - y_min)));
  endfunction

endpackage

// File: rtl/bullet_disc.sv
// Combinational filled-disc coverage test for one bullet centred at (cx, cy).
module bullet_disc
  import bullet_pkg::*;
#(
  parameter int unsigned RADIUS = 5
) (
  input  logic [COORD_W-1:0] xx,
  input  logic [COORD_W-1:0] yy,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               disc_on
);

  localparam int unsigned SQ_W = 2 * COORD_W + 2;
  localparam logic [SQ_W-1:0] R2 = SQ_W'(RADIUS * RADIUS);

  logic signed [COORD_W:0] dx, dy;
  logic signed [SQ_W-1:0]  dx_e, dy_e;
  logic        [SQ_W-1:0]  dx2, dy2, dist2;

  // Full-width squared distance; no operand is narrower than its true range.
  always_comb begin
    dx      = $signed({1'b0, xx}) - $signed({1'b0, cx});
    dy      = $signed({1'b0, yy}) - $signed({1'b0, cy});
    dx_e    = SQ_W'(dx);
    dy_e    = SQ_W'(dy);
    dx2     = $unsigned(dx_e * dx_e);
    dy2     = $unsigned(dy_e * dy_e);
    dist2   = dx2 + dy2;
    disc_on = (dist2 <= R2);
  end

endmodule

// File: rtl/bullet_pattern_gen.sv
// N-bullet bouncing sprite engine. Optional heart/bullet hit pulse is built
// only when BULLET_COLLIDE_EN is defined; otherwise bullet_hit is tied low.
module bullet_pattern_gen
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned RADIUS      = 5,
  parameter int unsigned X0          = 230,
  parameter int unsigned X_SPACING   = 40,
  parameter int unsigned Y_MIN       = 220,
  parameter int unsigned Y_MAX       = 375,
  parameter int unsigned STEP        = 6,
  parameter int unsigned FRAME_DIV   = 3,
  parameter int unsigned PHASE       = 24
) (
  input  logic               Pclk,
  input  logic               Rst_n,
  input  logic [COORD_W-1:0] xx,
  input  logic [COORD_W-1:0] yy,
  input  logic               aactive,
  input  logic               run,
  input  logic               restart,
  input  logic               heart_on,
  output logic               BulletSpriteOn,
  output logic               bullet_hit
);

  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef logic [COORD_W:0] ext_t;
  localparam ext_t YMIN_E = ext_t'(Y_MIN);
  localparam ext_t YMAX_E = ext_t'(Y_MAX);
  localparam ext_t STEP_E = ext_t'(STEP);
  localparam logic [COORD_W-1:0] YMIN_C = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

  fsm_t              state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [COORD_W-1:0] y_q [NUM_BULLETS];
  logic [COORD_W-1:0] y_d [NUM_BULLETS];
  dir_t              dir_q [NUM_BULLETS];
  dir_t              dir_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] disc_on;

  logic frame_tick, div_wrap, move_tick;

  assign frame_tick = (xx == H_LAST) && (yy == V_LAST);
  assign div_wrap   = (div_q == DIV_LAST);
  assign move_tick  = frame_tick && (state_q == RUN) && div_wrap && !restart;

  // Run-control state register.
  always_ff @(posedge Pclk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: restart overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run)  state_d = RUN;
        RUN:     if (!run) state_d = HOLD;
        HOLD:    if (run)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame divider: advances only while running, cleared by restart.
  always_ff @(posedge Pclk) begin
    if (!Rst_n || restart) begin
      div_q <= '0;
    end else if (frame_tick && (state_q == RUN)) begin
      div_q <= div_wrap ? '0 : div_q + 1'b1;
    end
  end

  // Per-bullet bounce step; compares are done one bit wider so they never wrap.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      y_d[i]   = y_q[i];
      dir_d[i] = dir_q[i];
      if (restart) begin
        y_d[i]   = start_y(i, PHASE, Y_MIN, Y_MAX);
        dir_d[i] = DOWN;
      end else if (move_tick) begin
        if (dir_q[i] == DOWN) begin
          if (ext_t'(y_q[i]) + STEP_E >= YMAX_E) begin
            y_d[i]   = YMAX_C;
            dir_d[i] = UP;
          end else begin
            y_d[i] = y_q[i] + STEP_C;
          end
        end else begin
          if (ext_t'(y_q[i]) <= YMIN_E + STEP_E) begin
            y_d[i]   = YMIN_C;
            dir_d[i] = DOWN;
          end else begin
            y_d[i] = y_q[i] - STEP_C;
          end
        end
      end
    end
  end

  // Position/direction registers, loaded with the staggered start pattern on reset.
  always_ff @(posedge Pclk) begin
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!Rst_n) begin
        y_q[i]   <= start_y(i, PHASE, Y_MIN, Y_MAX);
        dir_q[i] <= DOWN;
      end else begin
        y_q[i]   <= y_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_disc
    localparam logic [COORD_W-1:0] CX = COORD_W'(X0 + g * X_SPACING);
    bullet_disc #(.RADIUS(RADIUS)) u_disc (
      .xx      (xx),
      .yy      (yy),
      .cx      (CX),
      .cy      (y_q[g]),
      .disc_on (disc_on[g])
    );
  end

  // Registered coverage, one pixel of latency like the other sprites.
  always_ff @(posedge Pclk) begin
    if (!Rst_n) BulletSpriteOn <= 1'b0;
    else        BulletSpriteOn <= aactive & (|disc_on);
  end

`ifdef BULLET_COLLIDE_EN
  logic hit_seen_q;
  logic hit_now;

  // heart_on and BulletSpriteOn are both one cycle behind xx/yy, so they line up directly.
  assign hit_now = heart_on & BulletSpriteOn & ~hit_seen_q & ~restart;

  // One hit pulse per frame; the flag re-arms at each frame tick or restart.
  always_ff @(posedge Pclk) begin
    if (!Rst_n) begin
      hit_seen_q <= 1'b0;
      bullet_hit <= 1'b0;
    end else begin
      bullet_hit <= hit_now;
      if (restart || frame_tick) hit_seen_q <= 1'b0;
      else if (hit_now)          hit_seen_q <= 1'b1;
    end
  end
`else
  logic unused_heart;
  assign unused_heart = heart_on;
  assign bullet_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_pattern_gen.sv
// Self-checking bench for bullet_pattern_gen (BULLET_COLLIDE_EN optional).
module tb_bullet_pattern_gen;

  localparam int NB   = 4;
  localparam int R    = 5;
  localparam int X0   = 230;
  localparam int XS   = 40;
  localparam int YMIN = 220;
  localparam int YMAX = 375;
  localparam int STEP = 6;
  localparam int FDIV = 3;
  localparam int PH   = 24;
`ifdef BULLET_COLLIDE_EN
  localparam bit COLLIDE = 1'b1;
`else
  localparam bit COLLIDE = 1'b0;
`endif

  logic       Pclk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [9:0] xx = '0, yy = '0;
  logic       aactive = 1'b0, run = 1'b0, restart = 1'b0, heart_on = 1'b0;
  logic       BulletSpriteOn, bullet_hit;

  bullet_pattern_gen #(
    .NUM_BULLETS(NB), .RADIUS(R), .X0(X0), .X_SPACING(XS), .Y_MIN(YMIN),
    .Y_MAX(YMAX), .STEP(STEP), .FRAME_DIV(FDIV), .PHASE(PH)
  ) dut (
    .Pclk(Pclk), .Rst_n(Rst_n), .xx(xx), .yy(yy), .aactive(aactive), .run(run),
    .restart(restart), .heart_on(heart_on),
    .BulletSpriteOn(BulletSpriteOn), .bullet_hit(bullet_hit)
  );

  always #20 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;
  int hit_count = 0;
  bit run_r = 1'b0;

  // Reference model: bullet centres, directions, frames since last move, moving flag.
  int ym [NB];
  bit up_m [NB];
  int frames_m;
  bit moving_m;
  bit exp_on, exp_hit, hit_seen_m;

  function automatic bit any_disc(int x, int y);
    for (int b = 0; b < NB; b++) begin
      int dx = x - (X0 + b * XS);
      int dy = y - ym[b];
      if (dx * dx + dy * dy <= R * R) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reload();
    for (int b = 0; b < NB; b++) begin
      ym[b]   = YMIN + ((b * PH) % (YMAX - YMIN));
      up_m[b] = 1'b0;
    end
    frames_m = 0;
  endfunction

  function automatic void model_move();
    for (int b = 0; b < NB; b++) begin
      if (!up_m[b]) begin
        if (ym[b] + STEP >= YMAX) begin ym[b] = YMAX; up_m[b] = 1'b1; end
        else ym[b] = ym[b] + STEP;
      end else begin
        if (ym[b] - STEP <= YMIN) begin ym[b] = YMIN; up_m[b] = 1'b0; end
        else ym[b] = ym[b] - STEP;
      end
    end
  endfunction

  function automatic void model_step(bit rst_n, int x, int y, bit act, bit rn, bit rs, bit heart);
    bit tick, on_n, hit_n;
    if (!rst_n) begin
      model_reload();
      moving_m = 1'b0; hit_seen_m = 1'b0; exp_on = 1'b0; exp_hit = 1'b0;
      return;
    end
    tick  = (x == 639) && (y == 479);
    on_n  = act && any_disc(x, y);
    hit_n = COLLIDE && heart && exp_on && !hit_seen_m && !rs;
    if (rs || tick) hit_seen_m = 1'b0;
    else if (hit_n) hit_seen_m = 1'b1;
    if (rs) model_reload();
    else if (tick && moving_m) begin
      frames_m++;
      if (frames_m == FDIV) begin frames_m = 0; model_move(); end
    end
    moving_m = !rs && rn;
    exp_on   = on_n;
    exp_hit  = hit_n;
  endfunction

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(bit rst_n, int x, int y, bit act, bit rn, bit rs, bit heart);
    Rst_n = rst_n; xx = 10'(x); yy = 10'(y); aactive = act; run = rn;
    restart = rs; heart_on = heart;
    @(posedge Pclk);
    model_step(rst_n, x, y, act, rn, rs, heart);
    #1;
    chk("model_sprite", BulletSpriteOn, exp_on);
    chk("model_hit", bullet_hit, exp_hit);
    if (bullet_hit === 1'b1) hit_count++;
  endtask

  task automatic frame_tick(int n);
    for (int k = 0; k < n; k++) do_cycle(1, 639, 479, 0, run_r, 0, 0);
  endtask

  // Probe just inside and just outside the top and bottom of bullet i's disc.
  task automatic check_y(int i, int yexp, string tag);
    int cx = X0 + i * XS;
    do_cycle(1, cx, yexp + R, 1, run_r, 0, 0);     chk({tag, "_bot_in"},  BulletSpriteOn, 1'b1);
    do_cycle(1, cx, yexp + R + 1, 1, run_r, 0, 0); chk({tag, "_bot_out"}, BulletSpriteOn, 1'b0);
    do_cycle(1, cx, yexp - R, 1, run_r, 0, 0);     chk({tag, "_top_in"},  BulletSpriteOn, 1'b1);
    do_cycle(1, cx, yexp - R - 1, 1, run_r, 0, 0); chk({tag, "_top_out"}, BulletSpriteOn, 1'b0);
  endtask

  typedef struct {
    int x;
    int y;
    bit act;
    bit exp_on;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses_exp;
    tbl[0] = '{235, 220, 1, 1};
    tbl[1] = '{230, 215, 1, 1};
    tbl[2] = '{233, 224, 1, 1};
    tbl[3] = '{236, 220, 1, 0};
    tbl[4] = '{234, 224, 1, 0};
    tbl[5] = '{230, 220, 0, 0};
    tbl[6] = '{230, 220, 1, 1};
    tbl[7] = '{270, 244, 1, 1};
    tbl[8] = '{270, 250, 1, 0};
    tbl[9] = '{350, 292, 1, 1};
    pulses_exp = COLLIDE ? 1 : 0;

    // Reset mid-frame.
    do_cycle(0, 300, 200, 1, 1, 0, 1);
    do_cycle(0, 301, 200, 1, 1, 0, 1);
    chk("rst_sprite", BulletSpriteOn, 1'b0);
    chk("rst_hit", bullet_hit, 1'b0);
    check_y(0, 220, "rst_y0");
    check_y(1, 244, "rst_y1");

    // Coverage vectors with bullets at their start positions.
    for (int k = 0; k < 10; k++) begin
      do_cycle(1, tbl[k].x, tbl[k].y, tbl[k].act, 0, 0, 0);
      chk($sformatf("cov%0d", k), BulletSpriteOn, tbl[k].exp_on);
    end

    // Movement every third frame.
    run_r = 1'b1;
    do_cycle(1, 0, 0, 0, run_r, 0, 0);
    frame_tick(2); check_y(0, 220, "div2");
    frame_tick(1); check_y(0, 226, "div3");
    frame_tick(3); check_y(0, 232, "div6");

    // Hold freezes position and divider.
    frame_tick(1);
    run_r = 1'b0;
    do_cycle(1, 0, 0, 0, run_r, 0, 0);
    frame_tick(10); check_y(0, 232, "hold10");
    run_r = 1'b1;
    do_cycle(1, 0, 0, 0, run_r, 0, 0);
    frame_tick(1); check_y(0, 232, "resume1");
    frame_tick(1); check_y(0, 238, "resume2");

    // Restart coincident with a move tick wins.
    frame_tick(2);
    do_cycle(1, 639, 479, 0, run_r, 1, 0);
    check_y(0, 220, "rsmove_y0");
    check_y(1, 244, "rsmove_y1");

    // Bounce at both limits.
    frame_tick(75); check_y(0, 370, "b370");
    frame_tick(3);  check_y(0, 375, "b375");
    frame_tick(3);  check_y(0, 369, "b369");
    frame_tick(75); check_y(0, 220, "b220");
    frame_tick(3);  check_y(0, 226, "b226");

    // Collision: one pulse per frame for a 12-pixel overlap.
    run_r = 1'b0;
    do_cycle(1, 0, 0, 0, run_r, 1, 0);
    frame_tick(1);
    hit_count = 0;
    for (int k = 0; k < 12; k++) do_cycle(1, 225 + k, 220, 1, run_r, 0, 1);
    do_cycle(1, 0, 0, 0, run_r, 0, 1);
    chk("hit_frame_k", 1'(hit_count == pulses_exp), 1'b1);
    hit_count = 0;
    for (int k = 0; k < 12; k++) do_cycle(1, 225 + k, 221, 1, run_r, 0, 1);
    do_cycle(1, 0, 0, 0, run_r, 0, 1);
    chk("hit_same_frame", 1'(hit_count == 0), 1'b1);
    frame_tick(1);
    hit_count = 0;
    for (int k = 0; k < 12; k++) do_cycle(1, 225 + k, 220, 1, run_r, 0, 1);
    do_cycle(1, 0, 0, 0, run_r, 0, 1);
    chk("hit_frame_k1", 1'(hit_count == pulses_exp), 1'b1);

    // Randomized traffic against the model, with one mid-run reset.
    run_r = 1'b1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) == 0) run_r = !run_r;
      if (f == 75) do_cycle(0, 400, 300, 1, run_r, 0, 0);
      for (int p = 0; p < 12; p++) begin
        int b  = int'($urandom_range(0, NB - 1));
        int px = X0 + b * XS + int'($urandom_range(0, 14)) - 7;
        int py = ym[b] + int'($urandom_range(0, 14)) - 7;
        do_cycle(1, px, py, $urandom_range(0, 7) != 0, run_r,
                 $urandom_range(0, 150) == 0, 1'($urandom_range(0, 1)));
      end
      frame_tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
